// File: rtl/wb_fetch_unpacker.sv
// wb_fetch_unpacker
// Consumer side of the Wishbone block-fetch unit. Requests a FETCH-word block
// whenever the whole block fits in the word FIFO, captures SRAM read data on
// every fetch-bus acknowledge, and serialises buffered words into an 8-bit
// valid/ready stream, least-significant byte first, marking each block's last byte.
module wb_fetch_unpacker #(
  parameter int WIDTH = 32,
  parameter int FETCH = 8,
  parameter int DEPTH = 16,
  parameter int DBITS = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             flush_i,
  output logic             fetch_o,
  input  logic             cyc_i,
  input  logic             ack_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [7:0]       m_data_o,
  output logic             m_last_o,
  output logic [DBITS:0]   level_o,
  output logic             busy_o,
  output logic             overflow_o
);

  localparam int CBITS = (FETCH > 1) ? $clog2(FETCH) : 1;
  localparam int LW    = DBITS + 1;
  localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0]    LVL_ROOM = LW'(DEPTH - FETCH);
  localparam logic [CBITS-1:0] CNT_LAST = CBITS'(FETCH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  state_t             state_r;
  logic               run_r;
  logic               fetch_r;
  logic               busy_r;
  logic               ovf_r;
  logic               discard_r;
  logic [CBITS-1:0]   ack_cnt_r;
  logic [WIDTH-1:0]   mem_r [DEPTH];
  logic [DBITS-1:0]   wr_ptr_r;
  logic [DBITS-1:0]   rd_ptr_r;
  logic [LW-1:0]      level_r;
  logic [1:0]         idx_r;
  logic [CBITS-1:0]   blk_cnt_r;

  logic               bus_ack_s;
  logic               in_busy_s;
  logic               full_s;
  logic               room_s;
  logic               valid_s;
  logic               xfer_s;
  logic               pop_s;
  logic               accept_s;
  logic               push_s;
  logic               drop_s;
  logic               last_ack_s;
  logic [WIDTH-1:0]   head_s;
  logic [7:0]         byte_s;

  assign bus_ack_s  = cyc_i & ack_i;
  assign in_busy_s  = (state_r == ST_BUSY);
  assign full_s     = (level_r == LVL_FULL);
  assign room_s     = (level_r <= LVL_ROOM);
  assign valid_s    = (level_r != {LW{1'b0}});
  assign xfer_s     = valid_s & m_ready_i;
  assign pop_s      = xfer_s & (idx_r == 2'd3);
  // Acks of a flushed block are counted by the FSM but never stored.
  assign accept_s   = in_busy_s & bus_ack_s & ~discard_r & ~flush_i;
  // A full FIFO still takes the word when the head is popped on the same edge.
  assign push_s     = accept_s & (~full_s | pop_s);
  assign drop_s     = bus_ack_s & (~in_busy_s | (accept_s & ~push_s));
  assign last_ack_s = in_busy_s & bus_ack_s & (ack_cnt_r == CNT_LAST);

  assign fetch_o    = fetch_r;
  assign busy_o     = busy_r;
  assign overflow_o = ovf_r;
  assign level_o    = level_r;
  assign m_valid_o  = valid_s;
  assign m_data_o   = byte_s;
  assign m_last_o   = valid_s & (idx_r == 2'd3) & (blk_cnt_r == CNT_LAST);

  // Select the current byte of the head word, LSB first.
  always_comb begin
    head_s = mem_r[rd_ptr_r];
    byte_s = 8'h00;
    case (idx_r)
      2'd0:    byte_s = head_s[7:0];
      2'd1:    byte_s = head_s[15:8];
      2'd2:    byte_s = head_s[23:16];
      2'd3:    byte_s = head_s[31:24];
      default: byte_s = head_s[7:0];
    endcase
  end

  // Request FSM: one-cycle fetch pulse, then count acks until the block completes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= ST_IDLE;
      run_r     <= 1'b0;
      fetch_r   <= 1'b0;
      busy_r    <= 1'b0;
      ack_cnt_r <= {CBITS{1'b0}};
    end else begin
      run_r <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          busy_r <= 1'b0;
          if (run_r && enable_i && !flush_i && room_s) begin
            state_r <= ST_REQ;
            fetch_r <= 1'b1;
          end else begin
            fetch_r <= 1'b0;
          end
        end
        ST_REQ: begin
          fetch_r   <= 1'b0;
          busy_r    <= 1'b1;
          ack_cnt_r <= {CBITS{1'b0}};
          state_r   <= ST_BUSY;
        end
        ST_BUSY: begin
          fetch_r <= 1'b0;
          if (last_ack_s) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            ack_cnt_r <= {CBITS{1'b0}};
          end else if (bus_ack_s) begin
            ack_cnt_r <= ack_cnt_r + CBITS'(1);
          end else begin
            ack_cnt_r <= ack_cnt_r;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          fetch_r   <= 1'b0;
          busy_r    <= 1'b0;
          ack_cnt_r <= {CBITS{1'b0}};
        end
      endcase
    end
  end

  // Mark the in-flight block as discarded when it is flushed; cleared at block end.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      discard_r <= 1'b0;
    end else if (last_ack_s) begin
      discard_r <= 1'b0;
    end else if (flush_i && (state_r != ST_IDLE)) begin
      discard_r <= 1'b1;
    end else begin
      discard_r <= discard_r;
    end
  end

  // Sticky flag for acknowledges that could not be stored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Word storage: written at the tail on each accepted ack.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= dat_i;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // FIFO pointers, level, byte index and block word counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r  <= {DBITS{1'b0}};
      rd_ptr_r  <= {DBITS{1'b0}};
      level_r   <= {LW{1'b0}};
      idx_r     <= 2'd0;
      blk_cnt_r <= {CBITS{1'b0}};
    end else if (flush_i) begin
      wr_ptr_r  <= {DBITS{1'b0}};
      rd_ptr_r  <= {DBITS{1'b0}};
      level_r   <= {LW{1'b0}};
      idx_r     <= 2'd0;
      blk_cnt_r <= {CBITS{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + DBITS'(1);
      else        wr_ptr_r <= wr_ptr_r;
      if (xfer_s) idx_r <= idx_r + 2'd1;
      else        idx_r <= idx_r;
      if (pop_s) begin
        rd_ptr_r  <= rd_ptr_r + DBITS'(1);
        blk_cnt_r <= (blk_cnt_r == CNT_LAST) ? {CBITS{1'b0}} : blk_cnt_r + CBITS'(1);
      end else begin
        rd_ptr_r  <= rd_ptr_r;
        blk_cnt_r <= blk_cnt_r;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_fetch_unpacker.sv
// Directed self-checking bench for wb_fetch_unpacker.
module tb_wb_fetch_unpacker;

  logic        clk = 1'b0;
  logic        rst_ni, enable_i, flush_i, cyc_i, ack_i, m_ready_i;
  logic [31:0] dat_i;
  logic        fetch_o, m_valid_o, m_last_o, busy_o, overflow_o;
  logic [7:0]  m_data_o;
  logic [4:0]  level_o;

  int n_tests = 0;
  int n_fail  = 0;
  int fetch_cnt = 0;
  int fc0;
  logic [8:0] obs_q[$];
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  wb_fetch_unpacker dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .flush_i(flush_i),
    .fetch_o(fetch_o), .cyc_i(cyc_i), .ack_i(ack_i), .dat_i(dat_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .m_last_o(m_last_o), .level_o(level_o), .busy_o(busy_o),
    .overflow_o(overflow_o)
  );

  // Record fetch pulses and accepted stream bytes midway between active edges.
  always @(negedge clk) begin
    if (rst_ni === 1'b1 && fetch_o === 1'b1) fetch_cnt++;
    if (rst_ni === 1'b1 && m_valid_o === 1'b1 && m_ready_i === 1'b1)
      obs_q.push_back({m_last_o, m_data_o});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int b, input int n);
    return 32'h03020100 + 32'h04040404 * 32'(n) + 32'h20202020 * 32'(b);
  endfunction

  task automatic push_word(input logic [31:0] w, input bit last_word);
    for (int k = 0; k < 4; k++) begin
      logic l;
      l = last_word && (k == 3);
      exp_q.push_back({l, w[8*k +: 8]});
    end
  endtask

  task automatic send_acks(input int b, input int first, input int count, input bit keep);
    for (int n = first; n < first + count; n++) begin
      cyc_i = 1'b1; ack_i = 1'b1; dat_i = word_of(b, n);
      tick();
      if (keep) push_word(word_of(b, n), n == 7);
    end
    cyc_i = 1'b0; ack_i = 1'b0; dat_i = 32'h0;
  endtask

  task automatic wait_fetch(input string tag);
    int k;
    k = 0;
    while (fetch_o !== 1'b1 && k < 30) begin
      tick();
      k++;
    end
    chk(tag, fetch_o, 1);
  endtask

  task automatic drain(input string tag, input bit toggle);
    int k;
    k = 0;
    while ((m_valid_o === 1'b1 || level_o !== 5'd0) && k < 400) begin
      m_ready_i = toggle ? ~m_ready_i : 1'b1;
      tick();
      k++;
    end
    m_ready_i = 1'b0;
    chk(tag, m_valid_o, 0);
  endtask

  task automatic compare_stream(input string tag);
    int n;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s[%0d]", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst_ni = 1'b0; enable_i = 1'b0; flush_i = 1'b0; cyc_i = 1'b0; ack_i = 1'b0;
    m_ready_i = 1'b0; dat_i = 32'h0;
    repeat (3) tick();
    chk("rst_fetch", fetch_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_valid", m_valid_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_last", m_last_o, 0);
    chk("rst_data", m_data_o, 0);

    // Reset in the middle of a block after three acks.
    rst_ni = 1'b1; enable_i = 1'b1; m_ready_i = 1'b1;
    wait_fetch("t1_fetch");
    tick();
    chk("t1_busy", busy_o, 1);
    send_acks(7, 0, 3, 0);
    rst_ni = 1'b0;
    #1;
    chk("t1_busy_rst", busy_o, 0);
    chk("t1_level_rst", level_o, 0);
    chk("t1_valid_rst", m_valid_o, 0);
    chk("t1_fetch_rst", fetch_o, 0);
    tick();
    tick();
    rst_ni = 1'b1;
    obs_q.delete(); exp_q.delete();
    tick();
    chk("t1_edge1_no_fetch", fetch_o, 0);
    tick();
    chk("t1_edge2_fetch", fetch_o, 1);

    // Streaming block: bytes 0x00..0x1F, last on 0x1F only.
    enable_i = 1'b0;
    tick();
    chk("t2_busy", busy_o, 1);
    send_acks(0, 0, 8, 1);
    chk("t2_busy_done", busy_o, 0);
    drain("t2_drain", 0);
    compare_stream("t2");

    // Consumer stalled: exactly two requests fill the FIFO.
    m_ready_i = 1'b0; enable_i = 1'b1;
    fc0 = fetch_cnt;
    wait_fetch("t3_fetch1");
    tick();
    send_acks(1, 0, 8, 1);
    wait_fetch("t3_fetch2");
    tick();
    send_acks(2, 0, 8, 1);
    repeat (20) tick();
    chk("t3_fetches", fetch_cnt - fc0, 2);
    chk("t3_level", level_o, 16);
    chk("t3_ovf", overflow_o, 0);
    chk("t3_busy", busy_o, 0);
    chk("t3_valid", m_valid_o, 1);
    enable_i = 1'b0;

    // Pop and ack on the same edge near full: level holds, order preserved.
    m_ready_i = 1'b1;
    for (int k = 0; k < 100 && level_o !== 5'd8; k++) tick();
    m_ready_i = 1'b0;
    chk("t6_level_8", level_o, 8);
    enable_i = 1'b1;
    wait_fetch("t6_fetch");
    enable_i = 1'b0;
    m_ready_i = 1'b1;
    repeat (3) tick();
    m_ready_i = 1'b0;
    chk("t6_busy", busy_o, 1);
    send_acks(3, 0, 7, 1);
    chk("t6_level_15", level_o, 15);
    m_ready_i = 1'b1;
    send_acks(3, 7, 1, 1);
    m_ready_i = 1'b0;
    chk("t6_level_hold", level_o, 15);
    chk("t6_ovf", overflow_o, 0);
    chk("t6_busy_done", busy_o, 0);
    drain("t6_drain", 0);
    compare_stream("t6");

    // Flush after the fourth ack; remaining acks discarded.
    m_ready_i = 1'b0; enable_i = 1'b1;
    wait_fetch("t5_fetch");
    enable_i = 1'b0;
    tick();
    send_acks(4, 0, 4, 0);
    chk("t5_level_4", level_o, 4);
    chk("t5_valid_pre", m_valid_o, 1);
    flush_i = 1'b1; cyc_i = 1'b1; ack_i = 1'b1; dat_i = word_of(4, 4);
    tick();
    flush_i = 1'b0;
    chk("t5_valid_flush", m_valid_o, 0);
    chk("t5_level_flush", level_o, 0);
    send_acks(4, 5, 2, 0);
    chk("t5_busy_mid", busy_o, 1);
    chk("t5_level_mid", level_o, 0);
    send_acks(4, 7, 1, 0);
    chk("t5_busy_done", busy_o, 0);
    chk("t5_level_done", level_o, 0);
    chk("t5_ovf", overflow_o, 0);
    enable_i = 1'b1;
    wait_fetch("t5_refetch");
    enable_i = 1'b0;
    m_ready_i = 1'b1;
    tick();
    send_acks(5, 0, 8, 1);
    drain("t5_drain", 0);
    chk("t5_first_byte", (obs_q.size() > 0) ? 32'(obs_q[0]) : 32'hFFFF, 32'h0A0);
    compare_stream("t5");

    // Ack while idle sets overflow; toggled ready sees each byte once.
    m_ready_i = 1'b0; enable_i = 1'b1;
    wait_fetch("t4_fetch");
    enable_i = 1'b0;
    tick();
    send_acks(6, 0, 8, 1);
    tick();
    chk("t4_level_8", level_o, 8);
    chk("t4_ovf_pre", overflow_o, 0);
    cyc_i = 1'b1; ack_i = 1'b1; dat_i = 32'hDEADBEEF;
    tick();
    cyc_i = 1'b0; ack_i = 1'b0; dat_i = 32'h0;
    chk("t4_ovf_set", overflow_o, 1);
    tick();
    chk("t4_level_same", level_o, 8);
    drain("t4_drain", 1);
    compare_stream("t4");
    chk("t4_ovf_sticky", overflow_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
